// File: rtl/led_status_pkg.sv
// rtl/led_status_pkg.sv - shared LED bit map and sizing helpers for the LED status driver
package led_status_pkg;

    localparam int LED_BIT0   = 0;
    localparam int LED_BIT1   = 1;
    localparam int LED_BIT2   = 2;
    localparam int LED_BIT3   = 3;
    localparam int RGB0_G_BIT = 4;
    localparam int RGB1_G_BIT = 5;

    localparam int NUM_STRETCH      = 6;
    localparam int DEFAULT_PWM_BITS = 8;

    // Counter must hold STRETCH_CYCLES itself; a zero-cycle stretch still needs a 1-bit counter.
    function automatic int stretch_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_status_driver_pulse_stretcher.sv
// rtl/led_status_driver_pulse_stretcher.sv - holds a bit on for STRETCH_CYCLES after each rising edge
module pulse_stretcher
    import led_status_pkg::*;
#(
    parameter int STRETCH_CYCLES = 5_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    localparam int                CNT_W    = stretch_cnt_width(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(STRETCH_CYCLES);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A rising edge always reloads, so a retrigger mid-stretch restarts the full window.
    always_comb begin
        cnt_d = cnt_q;
        if (d && !prev_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= d;
            cnt_q  <= cnt_d;
        end
    end

    assign q = d | (cnt_q != '0);

endmodule

// File: rtl/led_status_driver.sv
// rtl/led_status_driver.sv - registers core status, stretches activity bits, heartbeat and PWM-dims board LEDs
module led_status_driver
    import led_status_pkg::*;
#(
    parameter int PWM_BITS       = DEFAULT_PWM_BITS,
    parameter int BRIGHTNESS     = 32,
    parameter int STRETCH_CYCLES = 5_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DIN,
    input  logic        HALT,
    input  logic        TICK,
    input  logic        SYS_RST,
    output logic [0:3]  led,
    output logic        led0_r,
    output logic        led0_g,
    output logic        led0_b,
    output logic        led1_r,
    output logic        led1_g,
    output logic        led1_b
);

    // One extra bit lets BRIGHTNESS = 2^PWM_BITS mean fully on.
    localparam logic [PWM_BITS:0] BRIGHT_CMP = (PWM_BITS + 1)'(BRIGHTNESS);

    logic [NUM_STRETCH-1:0] din_q;
    logic                   halt_q;
    logic                   sys_rst_q;
    logic                   hb_q, hb_d;
    logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [0:3]             led_q, led_d;
    logic [2:0]             rgb0_q, rgb0_d;
    logic [1:0]             rgb1_q, rgb1_d;

    logic [NUM_STRETCH-1:0] stretched;
    logic                   pwm_on;
    logic                   unused_din_hi;

    assign unused_din_hi = ^DIN[15:6];

    for (genvar i = 0; i < NUM_STRETCH; i++) begin : g_stretch
        pulse_stretcher #(
            .STRETCH_CYCLES(STRETCH_CYCLES)
        ) u_stretch (
            .CLK(CLK),
            .RST(RST),
            .d  (din_q[i]),
            .q  (stretched[i])
        );
    end

    always_comb begin
        hb_d      = hb_q ^ TICK;
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_on    = ({1'b0, pwm_cnt_q} < BRIGHT_CMP);

        led_d[0] = stretched[LED_BIT0] & pwm_on;
        led_d[1] = stretched[LED_BIT1] & pwm_on;
        led_d[2] = stretched[LED_BIT2] & pwm_on;
        led_d[3] = stretched[LED_BIT3] & pwm_on;

        rgb0_d = {halt_q & pwm_on, stretched[RGB0_G_BIT] & pwm_on, hb_q & pwm_on};
        rgb1_d = {stretched[RGB1_G_BIT] & pwm_on, sys_rst_q & pwm_on};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            din_q     <= '0;
            halt_q    <= 1'b0;
            sys_rst_q <= 1'b0;
            hb_q      <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
            rgb0_q    <= '0;
            rgb1_q    <= '0;
        end else begin
            din_q     <= DIN[NUM_STRETCH-1:0];
            halt_q    <= HALT;
            sys_rst_q <= SYS_RST;
            hb_q      <= hb_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            rgb0_q    <= rgb0_d;
            rgb1_q    <= rgb1_d;
        end
    end

    assign led    = led_q;
    assign led0_r = rgb0_q[2];
    assign led0_g = rgb0_q[1];
    assign led0_b = rgb0_q[0];
    assign led1_r = 1'b0;
    assign led1_g = rgb1_q[1];
    assign led1_b = rgb1_q[0];

endmodule

// File: tb/tb_led_status_driver.sv
// tb/tb_led_status_driver.sv - directed self-checking bench for led_status_driver
module tb_led_status_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        halt;
    logic        tick;
    logic        sys_rst;

    logic [0:3]  led_a, led_b4, led_z;
    logic        r0_a, g0_a, b0_a, r1_a, g1_a, b1_a;
    logic        r0_b4, g0_b4, b0_b4, r1_b4, g1_b4, b1_b4;
    logic        r0_z, g0_z, b0_z, r1_z, g1_z, b1_z;

    logic [9:0]  out_a, out_b4, out_z;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    led_status_driver #(.PWM_BITS(4), .BRIGHTNESS(16), .STRETCH_CYCLES(8)) dut (
        .CLK(clk), .RST(rst), .DIN(din), .HALT(halt), .TICK(tick), .SYS_RST(sys_rst),
        .led(led_a), .led0_r(r0_a), .led0_g(g0_a), .led0_b(b0_a),
        .led1_r(r1_a), .led1_g(g1_a), .led1_b(b1_a)
    );

    led_status_driver #(.PWM_BITS(4), .BRIGHTNESS(4), .STRETCH_CYCLES(8)) dut_b4 (
        .CLK(clk), .RST(rst), .DIN(din), .HALT(halt), .TICK(tick), .SYS_RST(sys_rst),
        .led(led_b4), .led0_r(r0_b4), .led0_g(g0_b4), .led0_b(b0_b4),
        .led1_r(r1_b4), .led1_g(g1_b4), .led1_b(b1_b4)
    );

    led_status_driver #(.PWM_BITS(4), .BRIGHTNESS(0), .STRETCH_CYCLES(8)) dut_b0 (
        .CLK(clk), .RST(rst), .DIN(din), .HALT(halt), .TICK(tick), .SYS_RST(sys_rst),
        .led(led_z), .led0_r(r0_z), .led0_g(g0_z), .led0_b(b0_z),
        .led1_r(r1_z), .led1_g(g1_z), .led1_b(b1_z)
    );

    assign out_a  = {led_a,  r0_a,  g0_a,  b0_a,  r1_a,  g1_a,  b1_a};
    assign out_b4 = {led_b4, r0_b4, g0_b4, b0_b4, r1_b4, g1_b4, b1_b4};
    assign out_z  = {led_z,  r0_z,  g0_z,  b0_z,  r1_z,  g1_z,  b1_z};

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [13:0] tick_pat;
        logic [13:0] hb_exp;
        int          ones;

        tick_pat = 14'b00011101001001;
        hb_exp   = 14'b00101100011100;

        // Reset held with all inputs active and TICK toggling
        rst = 1'b1; din = 16'hFFFF; halt = 1'b1; tick = 1'b0; sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tick = ~tick;
            check($sformatf("reset_hold[%0d]", i), out_a, 0);
            check($sformatf("reset_hold_b0[%0d]", i), out_z, 0);
        end
        rst = 1'b0; tick = 1'b0; cyc = 0;
        step();
        check("first_after_reset", out_a, 0);
        step();
        check("release_all_on", out_a, 10'h3F3);
        check("release_b0", out_z, 0);

        din = 16'h0000; halt = 1'b0; sys_rst = 1'b0;
        repeat (14) step();
        check("idle", out_a, 0);

        // Upper DIN bits never reach any output
        din = 16'hFFC0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("din_hi_ignored[%0d]", i), out_a, 0);
        end

        din = 16'h0001;
        step();
        check("latency_1cyc", out_a, 0);
        step();
        check("latency_2cyc", out_a, 10'h200);
        din = 16'hAAC1;
        step();
        check("latency_hi_a", out_a, 10'h200);
        din = 16'h5541;
        step();
        check("latency_hi_b", out_a, 10'h200);
        din = 16'h0000;
        repeat (12) step();
        check("latency_idle", out_a, 0);

        // Single-cycle pulse on DIN[4]
        for (int k = 0; k < 13; k++) begin
            din = (k == 0) ? 16'h0010 : 16'h0000;
            check($sformatf("stretch_single[%0d]", k), g0_a, (k >= 2 && k <= 10) ? 1 : 0);
            step();
        end

        // Retrigger four cycles after the first pulse
        for (int k = 0; k < 17; k++) begin
            din = (k == 0 || k == 4) ? 16'h0010 : 16'h0000;
            check($sformatf("stretch_retrig[%0d]", k), g0_a, (k >= 2 && k <= 14) ? 1 : 0);
            step();
        end

        // Heartbeat: three spaced ticks then three back-to-back
        for (int k = 0; k < 14; k++) begin
            tick = tick_pat[k];
            check($sformatf("heartbeat[%0d]", k), b0_a, hb_exp[k]);
            step();
        end
        tick = 1'b0;

        // PWM duty with HALT driving led0_r
        halt = 1'b1;
        step();
        step();
        ones = 0;
        for (int k = 0; k < 32; k++) begin
            check($sformatf("pwm_b4[%0d]", k), r0_b4, (((cyc - 1) % 16) < 4) ? 1 : 0);
            check($sformatf("pwm_b16[%0d]", k), r0_a, 1);
            check($sformatf("pwm_b0[%0d]", k), out_z, 0);
            if (r0_b4 === 1'b1) ones++;
            step();
        end
        check("pwm_b4_duty", ones, 8);

        // Reset in the middle of a DIN[5] stretch
        din = 16'h0020;
        step();
        step();
        check("rst_mid_pre_a", g1_a, 1);
        step();
        check("rst_mid_pre_b", g1_a, 1);
        rst = 1'b1;
        step();
        check("rst_mid_during", out_a, 0);
        rst = 1'b0; cyc = 0;
        for (int k = 0; k < 13; k++) begin
            din = (k == 0) ? 16'h0020 : 16'h0000;
            check($sformatf("rst_mid_led1_g[%0d]", k), g1_a, (k >= 2 && k <= 10) ? 1 : 0);
            if (k == 1) check("rst_mid_all_off", out_a, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
